// File: rtl/pe_operand_feeder_pkg.sv
// Shared types and constants for the PE operand feeder.
// Holds the FSM state enum, the operand width and parameter defaults.
package pe_operand_feeder_pkg;

    localparam int DATA_W    = 16;
    localparam int DEPTH_DEF = 4;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pe_operand_feeder_op_fifo.sv
// op_fifo: synchronous FIFO, no bypass (a push is poppable next cycle).
// Ports: clk, rst (sync, active-low), push/din, pop/dout, full, empty.
module op_fifo
    import pe_operand_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign dout = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_do_push)
            r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pe_operand_feeder.sv
// Feeds paired ifmap/filter operands from two FIFOs into a MAC PE.
// Ports: clk, rst, ifmap/filter write ports, start/cfg_len, pe_* and status.
module pe_operand_feeder
    import pe_operand_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifmap_valid,
    input  logic [DATA_W-1:0] ifmap_data,
    output logic              ifmap_ready,
    input  logic              filter_valid,
    input  logic [DATA_W-1:0] filter_data,
    output logic              filter_ready,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [DATA_W-1:0] pe_ifmap,
    output logic [DATA_W-1:0] pe_filter,
    output logic              pe_en,
    output logic              pe_clr,
    output logic              busy,
    output logic              done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic               w_pop;
    logic               r_pe_en;
    logic [DATA_W-1:0]  r_pe_ifmap;
    logic [DATA_W-1:0]  r_pe_filter;

    logic               w_if_full;
    logic               w_if_empty;
    logic [DATA_W-1:0]  w_if_dout;
    logic               w_fl_full;
    logic               w_fl_empty;
    logic [DATA_W-1:0]  w_fl_dout;

    op_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_if_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ifmap_valid),
        .din   (ifmap_data),
        .pop   (w_pop),
        .dout  (w_if_dout),
        .full  (w_if_full),
        .empty (w_if_empty)
    );

    op_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_fl_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (filter_valid),
        .din   (filter_data),
        .pop   (w_pop),
        .dout  (w_fl_dout),
        .full  (w_fl_full),
        .empty (w_fl_empty)
    );

    assign ifmap_ready  = !w_if_full;
    assign filter_ready = !w_fl_full;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        w_cnt_nxt   = cfg_len;
                        w_state_nxt = ST_CLEAR;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_CLEAR: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // Pairs move together; a lone operand waits.
                if (!w_if_empty && !w_fl_empty) begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1))
                        w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pe_en     <= 1'b0;
            r_pe_ifmap  <= '0;
            r_pe_filter <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pe_en <= w_pop;
            if (w_pop) begin
                r_pe_ifmap  <= w_if_dout;
                r_pe_filter <= w_fl_dout;
            end
        end
    end

    // Clearing during reset keeps the PE accumulator in step with us.
    assign pe_clr    = !rst || (r_state == ST_CLEAR);
    assign pe_en     = r_pe_en;
    assign pe_ifmap  = r_pe_ifmap;
    assign pe_filter = r_pe_filter;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder: directed steps then random.
// Reference model tracks FIFO contents as queues and run progress per pair.
module tb_pe_operand_feeder;
    import pe_operand_feeder_pkg::*;

    localparam int DEPTH = 4;
    localparam int LEN_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifmap_valid = 1'b0;
    logic [15:0] ifmap_data = '0;
    logic        filter_valid = 1'b0;
    logic [15:0] filter_data = '0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        ifmap_ready;
    logic        filter_ready;
    logic [15:0] pe_ifmap;
    logic [15:0] pe_filter;
    logic        pe_en;
    logic        pe_clr;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pe_operand_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifmap_valid  (ifmap_valid),
        .ifmap_data   (ifmap_data),
        .ifmap_ready  (ifmap_ready),
        .filter_valid (filter_valid),
        .filter_data  (filter_data),
        .filter_ready (filter_ready),
        .start        (start),
        .cfg_len      (cfg_len),
        .pe_ifmap     (pe_ifmap),
        .pe_filter    (pe_filter),
        .pe_en        (pe_en),
        .pe_clr       (pe_clr),
        .busy         (busy),
        .done         (done)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m_if[$];
    logic [15:0] m_fl[$];
    bit          m_busy, m_run, m_done_next, m_busy_clr, m_en_next;
    int          m_len, m_cnt;
    logic [15:0] m_last_if, m_last_fl;
    bit          armed = 0;
    int          cyc = 0;
    int          psum, en_first, en_last, en_total;
    bit          saw_done, last_acc_if, last_acc_fl;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          acc_if, acc_fl, st_acc, pre_rst, exp_en, exp_done, exp_clr;
        logic [7:0]  len_s;
        logic [15:0] di, df, pi, pf;
        if (armed) begin
            chk("ifmap_ready", 32'(ifmap_ready), 32'(m_if.size() < DEPTH));
            chk("filter_ready", 32'(filter_ready), 32'(m_fl.size() < DEPTH));
        end
        pre_rst = rst;
        acc_if  = rst && ifmap_valid && (m_if.size() < DEPTH);
        acc_fl  = rst && filter_valid && (m_fl.size() < DEPTH);
        st_acc  = rst && start && !m_busy;
        len_s   = cfg_len;
        di      = ifmap_data;
        df      = filter_data;
        @(posedge clk);
        #1;
        cyc++;
        last_acc_if = acc_if;
        last_acc_fl = acc_fl;
        if (!pre_rst) begin
            m_if.delete();
            m_fl.delete();
            m_busy = 0; m_run = 0; m_done_next = 0; m_busy_clr = 0;
            m_en_next = 0; m_len = 0; m_cnt = 0;
            m_last_if = '0; m_last_fl = '0;
            exp_en = 0; exp_done = 0; exp_clr = 1;
            armed = 1;
        end else begin
            exp_en   = m_en_next;
            exp_done = m_done_next;
            exp_clr  = 0;
            if (m_busy_clr) begin
                m_busy = 0; m_run = 0; m_busy_clr = 0;
            end
            if (st_acc) begin
                m_busy = 1; m_len = int'(len_s); m_cnt = 0;
                if (len_s != 0) begin
                    exp_clr = 1; m_run = 1;
                end else begin
                    exp_done = 1;
                end
            end
            m_done_next = 0;
            if (exp_en) begin
                pi = m_if.pop_front();
                pf = m_fl.pop_front();
                m_last_if = pi; m_last_fl = pf;
                m_cnt++;
                if (m_cnt == m_len) m_done_next = 1;
            end
            if (acc_if) m_if.push_back(di);
            if (acc_fl) m_fl.push_back(df);
            if (exp_done) m_busy_clr = 1;
        end
        chk("pe_en", 32'(pe_en), 32'(exp_en));
        chk("pe_clr", 32'(pe_clr), 32'(exp_clr));
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("pe_ifmap", 32'(pe_ifmap), 32'(m_last_if));
        chk("pe_filter", 32'(pe_filter), 32'(m_last_fl));
        if (pe_en) begin
            if (en_first < 0) en_first = cyc;
            en_last = cyc;
            en_total++;
            psum += int'(pe_ifmap) * int'(pe_filter);
        end
        if (done) saw_done = 1;
        // A pop happens in the next edge iff we are running and both have data.
        m_en_next = m_run && !exp_clr && (m_cnt < m_len) &&
                    (m_if.size() > 0) && (m_fl.size() > 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        ifmap_valid = 1; ifmap_data = a;
        filter_valid = 1; filter_data = b;
        step();
        ifmap_valid = 0; filter_valid = 0;
    endtask

    task automatic go(input logic [7:0] len);
        cfg_len = len; start = 1;
        saw_done = 0; psum = 0; en_first = -1; en_last = -1; en_total = 0;
        step();
        start = 0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !saw_done; i++) step();
        chk("done_seen", 32'(saw_done), 32'd1);
    endtask

    int c0;

    initial begin
        // Reset
        rst = 0;
        idle(2);
        chk("rst_pe_clr", 32'(pe_clr), 32'd1);
        rst = 1;
        step();
        chk("post_rst_clr", 32'(pe_clr), 32'd0);
        chk("post_rst_rdy", 32'(ifmap_ready & filter_ready), 32'd1);

        // Prefetch then run
        push_pair(16'd1, 16'd4);
        push_pair(16'd2, 16'd5);
        push_pair(16'd3, 16'd6);
        go(8'd3);
        wait_done(20);
        chk("pf_psum", 32'(psum), 32'd32);
        chk("pf_en_total", 32'(en_total), 32'd3);
        chk("pf_en_span", 32'(en_last - en_first), 32'd2);
        idle(2);

        // Stall on empty FIFOs
        c0 = cyc;
        go(8'd2);
        while (!saw_done && (cyc - c0) < 40) begin
            filter_valid = ((cyc - c0) == 5) || ((cyc - c0) == 6);
            filter_data  = 16'(cyc - c0);
            ifmap_valid  = ((cyc - c0) == 9) || ((cyc - c0) == 10);
            ifmap_data   = 16'(100 + cyc - c0);
            step();
        end
        ifmap_valid = 0; filter_valid = 0;
        chk("stall_done", 32'(saw_done), 32'd1);
        chk("stall_first_en", 32'(en_first - c0), 32'd11);
        chk("stall_pairs", 32'(en_total), 32'd2);
        idle(2);

        // Backpressure
        for (int i = 0; i < 4; i++) push_pair(16'(16'h50 + i), 16'(16'h60 + i));
        chk("bp_if_full", 32'(ifmap_ready), 32'd0);
        chk("bp_fl_full", 32'(filter_ready), 32'd0);
        ifmap_valid = 1; ifmap_data = 16'h54;
        filter_valid = 1; filter_data = 16'h64;
        idle(2);
        go(8'd5);
        for (int i = 0; i < 20 && (ifmap_valid || filter_valid); i++) begin
            step();
            if (last_acc_if) ifmap_valid = 0;
            if (last_acc_fl) filter_valid = 0;
        end
        wait_done(20);
        chk("bp_pairs", 32'(en_total), 32'd5);
        idle(2);

        // Zero length leaves buffered data alone
        ifmap_valid = 1; ifmap_data = 16'h00aa;
        step();
        ifmap_valid = 0;
        go(8'd0);
        chk("zl_done", 32'(done), 32'd1);
        chk("zl_no_clr", 32'(pe_clr), 32'd0);
        step();
        filter_valid = 1; filter_data = 16'h00bb;
        step();
        filter_valid = 0;
        go(8'd1);
        wait_done(20);
        chk("zl_kept_if", 32'(pe_ifmap), 32'h00aa);
        chk("zl_kept_fl", 32'(pe_filter), 32'h00bb);
        idle(2);

        // Ignored start, then abort
        push_pair(16'd10, 16'd20);
        push_pair(16'd11, 16'd21);
        go(8'd4);
        idle(2);
        cfg_len = 8'd1; start = 1;
        step();
        start = 0;
        chk("ign_busy", 32'(busy), 32'd1);
        rst = 0;
        step();
        rst = 1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pe_if", 32'(pe_ifmap), 32'd0);
        chk("abort_pe_en", 32'(pe_en), 32'd0);
        saw_done = 0;
        idle(4);
        chk("abort_no_done", 32'(saw_done), 32'd0);
        chk("abort_rdy", 32'(ifmap_ready & filter_ready), 32'd1);
        push_pair(16'h33, 16'h44);
        go(8'd1);
        wait_done(20);
        chk("abort_fresh", 32'(pe_ifmap), 32'h33);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ifmap_valid  = 1'($urandom_range(0, 1));
            ifmap_data   = 16'($urandom);
            filter_valid = 1'($urandom_range(0, 1));
            filter_data  = 16'($urandom);
            start        = ($urandom_range(0, 7) == 0);
            cfg_len      = 8'($urandom_range(0, 6));
            rst          = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1; start = 0;
        for (int i = 0; i < 200 && m_busy; i++) begin
            ifmap_valid = 1; ifmap_data = 16'($urandom);
            filter_valid = 1; filter_data = 16'($urandom);
            step();
        end
        ifmap_valid = 0; filter_valid = 0;
        idle(3);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_operand_feeder.md
PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 Parameter DEPTH, default 4: entries per operand FIFO, power of two, at least 2.
REQ-002 Parameter LEN_W, default 8: width of the MAC-count configuration.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 ifmap_valid  input  1, ifmap_data  input  16, ifmap_ready  output  1: ifmap write port.
REQ-006 filter_valid  input  1, filter_data  input  16, filter_ready  output  1: filter write port.
REQ-007 start  input  1: one-cycle request to run one dot product.
REQ-008 cfg_len  input  LEN_W: number of ifmap/filter pairs per dot product, sampled on an accepted start.
REQ-009 pe_ifmap  output  16, pe_filter  output  16: operands to the PE.
REQ-010 pe_en  output  1: PE accumulate enable, valid with pe_ifmap/pe_filter.
REQ-011 pe_clr  output  1: active-high clear driven to the PE reset input.
REQ-012 busy  output  1: high whenever state is not IDLE.
REQ-013 done  output  1: one-cycle pulse; PE output_psum is final in this cycle.

Function
REQ-014 Each operand buffers in its own DEPTH-entry FIFO; the write handshake is valid AND ready; ready = NOT full.
REQ-015 FIFO writes are accepted in every state, including IDLE, so operands can be prefetched.
REQ-016 A FIFO never bypasses: data written in cycle t is poppable no earlier than cycle t+1.
REQ-017 A push to a full FIFO cannot occur (ready low); a pop of an empty FIFO never occurs.
REQ-018 States: IDLE, CLEAR, RUN, FLUSH, DONE.
REQ-019 IDLE: start with cfg_len != 0 latches cfg_len into a down-counter and moves to CLEAR.
REQ-020 IDLE: start with cfg_len == 0 moves to DONE without clearing, issuing no pe_en.
REQ-021 start is ignored outside IDLE.
REQ-022 CLEAR lasts exactly one cycle, with pe_clr=1 and pe_en=0; then RUN.
REQ-023 RUN: when both FIFOs are non-empty, pop both in the same cycle and decrement the counter; otherwise stall with no pop.
REQ-024 The pair popped in cycle t appears on pe_ifmap/pe_filter with pe_en=1 in cycle t+1 (registered outputs).
REQ-025 pe_en=0 in any cycle not following a pop; pe_ifmap/pe_filter hold their last value while pe_en=0.
REQ-026 The pop that brings the counter to 0 moves RUN to FLUSH; pe_en=1 in FLUSH presents the last pair.
REQ-027 FLUSH -> DONE; DONE asserts done=1 for one cycle and then returns to IDLE.
REQ-028 Latency: the last pop occurs in cycle t and done is asserted in cycle t+2.
REQ-029 Exactly cfg_len pe_en cycles occur between the pe_clr cycle and done.
REQ-030 Operands are passed unmodified; no arithmetic is performed on data.

Reset
REQ-031 While rst=0 at a clock edge: state=IDLE, both FIFOs empty, counter=0, pe_en=0, pe_ifmap=0, pe_filter=0, done=0, busy=0.
REQ-032 pe_clr=1 during reset, so the PE accumulator is cleared with the feeder.
REQ-033 Reset asserted mid-operation aborts the run and discards buffered operands; no done is issued for the aborted run.
REQ-034 In the first cycle after reset: ifmap_ready=1, filter_ready=1, pe_clr=0.

Structure
REQ-035 Shared package holds the state enum, DATA_W=16, and the default values of DEPTH and LEN_W.
REQ-036 A single sub-module op_fifo (synchronous FIFO: push, pop, full, empty) is instantiated once per operand.
REQ-037 pe_operand_feeder instantiates no PE; the parent wires pe_* to pe.input_ifmap, pe.input_filter, pe.en and pe.rst.

Verification
REQ-038 Prefetch, then run: prefetch 3 ifmap (1,2,3) and 3 filter (4,5,6), then start with cfg_len=3 -> pe_clr for 1 cycle, then 3 consecutive pe_en cycles with pairs (1,4),(2,5),(3,6), done 2 cycles after the last pop; PE psum=32.
REQ-039 Stall: start with cfg_len=2 on empty FIFOs; write filter at cycle 5 and ifmap at cycle 9 -> no pe_en before cycle 11, busy held throughout, done after 2 pairs.
REQ-040 Backpressure: write 5 ifmap words with DEPTH=4 while IDLE -> ifmap_ready=0 after the 4th accept, 5th word held until a pop, data order preserved.
REQ-041 Zero length: start with cfg_len=0 -> done pulse 1 cycle later, no pe_clr, no pe_en, FIFOs untouched.
REQ-042 Ignored start and abort: start during RUN is ignored; rst=0 mid-RUN -> all outputs at reset values next cycle, FIFOs empty, no done.
